// File: rtl/barrel_align_pkg.sv
// Shared types and default constants for the barrel aligner.
// The FSM state type and the default training/lock parameters live here.
package barrel_align_pkg;

  typedef enum logic [1:0] {
    StSearch,
    StCheck,
    StLocked
  } align_state_e;

  localparam logic [7:0]  DefSyncPat = 8'hBC;
  localparam int unsigned DefLockCnt = 3;
  localparam int unsigned DefLossCnt = 2;

endpackage

// File: rtl/barrel_rot.sv
// Combinational right-rotate of a word by a variable amount.
// Feeds both the training compare and the output register in the aligner.
module barrel_rot #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned RotW  = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] in_i,
  input  logic [RotW-1:0]  amt_i,
  output logic [WIDTH-1:0] out_o
);

  always_comb begin
    out_o = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      out_o[i] = in_i[(i + int'(amt_i)) % int'(WIDTH)];
    end
  end

endmodule

// File: rtl/barrel_aligner.sv
// Word aligner: hunts for the rotation that maps training words onto SYNC_PAT.
// Optional relock statistics counter is built when ALIGN_STATS_EN is defined.
module barrel_aligner
  import barrel_align_pkg::*;
#(
  parameter  int unsigned      WIDTH    = 8,
  parameter  logic [WIDTH-1:0] SYNC_PAT = WIDTH'(DefSyncPat),
  parameter  int unsigned      LOCK_CNT = DefLockCnt,
  parameter  int unsigned      LOSS_CNT = DefLossCnt,
  localparam int unsigned      RotW     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] din,
  input  logic             train,
  output logic             dout_valid,
  output logic [WIDTH-1:0] dout,
  output logic [RotW-1:0]  rot,
  output logic             locked
`ifdef ALIGN_STATS_EN
  ,
  output logic [15:0]      relock_cnt
`endif
);

  localparam int unsigned MatchW = $clog2(LOCK_CNT + 1);
  localparam int unsigned MissW  = $clog2(LOSS_CNT + 1);

  align_state_e      state_q, state_d;
  logic [RotW-1:0]   rot_q, rot_d;
  logic [MatchW-1:0] match_q, match_d;
  logic [MissW-1:0]  miss_q, miss_d;
  logic [WIDTH-1:0]  dout_q, dout_d;
  logic              dout_valid_q;
  logic [WIDTH-1:0]  aligned;
  logic              hit;
  logic              train_ev;

  barrel_rot #(
    .WIDTH (WIDTH)
  ) u_rot (
    .in_i  (din),
    .amt_i (rot_q),
    .out_o (aligned)
  );

  assign hit      = (aligned == SYNC_PAT);
  assign train_ev = din_valid & train;
  assign dout_d   = din_valid ? aligned : dout_q;

  always_comb begin
    state_d = state_q;
    rot_d   = rot_q;
    match_d = match_q;
    miss_d  = miss_q;
    if (train_ev) begin
      unique case (state_q)
        StSearch: begin
          if (hit) begin
            match_d = MatchW'(1);
            state_d = (LOCK_CNT == 1) ? StLocked : StCheck;
          end else begin
            rot_d = rot_q + RotW'(1);
          end
        end
        StCheck: begin
          if (hit) begin
            match_d = match_q + MatchW'(1);
            if (match_d == MatchW'(LOCK_CNT)) begin
              state_d = StLocked;
            end
          end else begin
            state_d = StSearch;
            rot_d   = rot_q + RotW'(1);
            match_d = '0;
          end
        end
        StLocked: begin
          if (hit) begin
            miss_d = '0;
          end else if (miss_q + MissW'(1) == MissW'(LOSS_CNT)) begin
            state_d = StSearch;
            rot_d   = rot_q + RotW'(1);
            match_d = '0;
            miss_d  = '0;
          end else begin
            miss_d = miss_q + MissW'(1);
          end
        end
        default: begin
          state_d = StSearch;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StSearch;
      rot_q        <= '0;
      match_q      <= '0;
      miss_q       <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rot_q        <= rot_d;
      match_q      <= match_d;
      miss_q       <= miss_d;
      dout_q       <= dout_d;
      dout_valid_q <= din_valid;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign rot        = rot_q;
  assign locked     = (state_q == StLocked);

`ifdef ALIGN_STATS_EN
  logic [15:0] relock_q, relock_d;
  logic        leave_lock;

  assign leave_lock = (state_q == StLocked) && (state_d == StSearch);
  assign relock_d   = (leave_lock && relock_q != 16'hFFFF) ? relock_q + 16'd1 : relock_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      relock_q <= '0;
    end else begin
      relock_q <= relock_d;
    end
  end

  assign relock_cnt = relock_q;
`endif

endmodule

// File: tb/tb_barrel_aligner.sv
// Directed self-checking bench for barrel_aligner (default parameters).
// Relock counter checks are compiled in when ALIGN_STATS_EN is defined.
module tb_barrel_aligner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din_valid = 1'b0;
  logic [7:0] din = 8'h00;
  logic       train = 1'b0;
  logic       dout_valid;
  logic [7:0] dout;
  logic [2:0] rot;
  logic       locked;
`ifdef ALIGN_STATS_EN
  logic [15:0] relock_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  barrel_aligner dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_valid  (din_valid),
    .din        (din),
    .train      (train),
    .dout_valid (dout_valid),
    .dout       (dout),
    .rot        (rot),
    .locked     (locked)
`ifdef ALIGN_STATS_EN
    ,
    .relock_cnt (relock_cnt)
`endif
  );

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic drive(input logic v, input logic t, input logic [7:0] d);
    din_valid = v;
    train     = t;
    din       = d;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    din_valid = 1'b0;
    train = 1'b0;
    din = 8'h00;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    pulse_reset();
    n_cmp++;
    if (rot !== 3'd0) begin
      n_bad++; $display("FAIL reset_rot: got %0d want 0", rot);
    end
    n_cmp++;
    if (locked !== 1'b0) begin
      n_bad++; $display("FAIL reset_locked: got %b want 0", locked);
    end
    n_cmp++;
    if (dout_valid !== 1'b0 || dout !== 8'h00) begin
      n_bad++; $display("FAIL reset_dout: got v=%b d=%h want v=0 d=00", dout_valid, dout);
    end
  endtask

  task automatic test_search_lock();
    logic [2:0] exp_rot [6] = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3};
    logic       exp_lk  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 8'hE5);
      n_cmp++;
      if (rot !== exp_rot[i] || locked !== exp_lk[i]) begin
        n_bad++;
        $display("FAIL search_lock w%0d: got rot=%0d lk=%b want rot=%0d lk=%b",
                 i, rot, locked, exp_rot[i], exp_lk[i]);
      end
    end
    n_cmp++;
    if (dout_valid !== 1'b1 || dout !== 8'hBC) begin
      n_bad++; $display("FAIL search_dout: got v=%b d=%h want v=1 d=bc", dout_valid, dout);
    end
  endtask

  task automatic test_passthrough();
    drive(1'b1, 1'b0, 8'h5A);
    n_cmp++;
    if (dout_valid !== 1'b1 || dout !== 8'h4B) begin
      n_bad++; $display("FAIL pass_dout: got v=%b d=%h want v=1 d=4b", dout_valid, dout);
    end
    n_cmp++;
    if (rot !== 3'd3 || locked !== 1'b1) begin
      n_bad++; $display("FAIL pass_state: got rot=%0d lk=%b want rot=3 lk=1", rot, locked);
    end
    drive(1'b0, 1'b0, 8'h00);
    n_cmp++;
    if (dout_valid !== 1'b0 || locked !== 1'b1) begin
      n_bad++; $display("FAIL pass_idle: got v=%b lk=%b want v=0 lk=1", dout_valid, locked);
    end
  endtask

  task automatic test_loss();
    // miss, hit (clears miss count), miss, miss -> unlock on the last one
    logic [7:0] word   [4] = '{8'h79, 8'hE5, 8'h79, 8'h79};
    logic       exp_lk [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [2:0] exp_rot[4] = '{3'd3, 3'd3, 3'd3, 3'd4};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, word[i]);
      n_cmp++;
      if (rot !== exp_rot[i] || locked !== exp_lk[i]) begin
        n_bad++;
        $display("FAIL loss w%0d: got rot=%0d lk=%b want rot=%0d lk=%b",
                 i, rot, locked, exp_rot[i], exp_lk[i]);
      end
    end
`ifdef ALIGN_STATS_EN
    n_cmp++;
    if (relock_cnt !== 16'd1) begin
      n_bad++; $display("FAIL loss_relock: got %0d want 1", relock_cnt);
    end
`endif
  endtask

  task automatic test_check_miss();
    pulse_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 8'hE5);
    n_cmp++;
    if (rot !== 3'd3 || locked !== 1'b0) begin
      n_bad++; $display("FAIL check_entry: got rot=%0d lk=%b want rot=3 lk=0", rot, locked);
    end
    drive(1'b1, 1'b1, 8'h00);
    n_cmp++;
    if (rot !== 3'd4 || locked !== 1'b0) begin
      n_bad++; $display("FAIL check_miss: got rot=%0d lk=%b want rot=4 lk=0", rot, locked);
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 8'h00);
      n_cmp++;
      if (rot !== 3'd4 || dout_valid !== 1'b0) begin
        n_bad++; $display("FAIL idle_hold c%0d: got rot=%0d v=%b want rot=4 v=0", i, rot, dout_valid);
      end
    end
    drive(1'b1, 1'b0, 8'h00);
    n_cmp++;
    if (rot !== 3'd4 || dout_valid !== 1'b1) begin
      n_bad++; $display("FAIL data_hold: got rot=%0d v=%b want rot=4 v=1", rot, dout_valid);
    end
`ifdef ALIGN_STATS_EN
    n_cmp++;
    if (relock_cnt !== 16'd0) begin
      n_bad++; $display("FAIL relock_reset: got %0d want 0", relock_cnt);
    end
`endif
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 8'h00);
    n_cmp++;
    if (rot !== 3'd7) begin
      n_bad++; $display("FAIL wrap_pre: got rot=%0d want 7", rot);
    end
    begin
      logic [2:0] exp_rot[5] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd1};
      logic       exp_lk [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 5; i++) begin
        drive(1'b1, 1'b1, 8'h79);
        n_cmp++;
        if (rot !== exp_rot[i] || locked !== exp_lk[i]) begin
          n_bad++;
          $display("FAIL wrap w%0d: got rot=%0d lk=%b want rot=%0d lk=%b",
                   i, rot, locked, exp_rot[i], exp_lk[i]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b0, 8'h79);
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (rot !== 3'd0 || locked !== 1'b0) begin
      n_bad++; $display("FAIL async_state: got rot=%0d lk=%b want rot=0 lk=0", rot, locked);
    end
    n_cmp++;
    if (dout_valid !== 1'b0 || dout !== 8'h00) begin
      n_bad++; $display("FAIL async_dout: got v=%b d=%h want v=0 d=00", dout_valid, dout);
    end
    din_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 8'hE5);
    n_cmp++;
    if (rot !== 3'd1 || locked !== 1'b0) begin
      n_bad++; $display("FAIL async_resume: got rot=%0d lk=%b want rot=1 lk=0", rot, locked);
    end
  endtask

  initial begin
    test_reset();
    test_search_lock();
    test_passthrough();
    test_loss();
    test_check_miss();
    test_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/barrel_aligner.md
BARREL_ALIGNER -- requirements
Module: barrel_aligner

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits (power of two, 4..32).
REQ-002 SHALL have parameter SYNC_PAT, default 8'hBC, training word with all WIDTH rotations distinct.
REQ-003 SHALL have parameter LOCK_CNT, default 3, consecutive matches needed to lock (>=1).
REQ-004 SHALL have parameter LOSS_CNT, default 2, consecutive training misses needed to drop lock (>=1).
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port din_valid  input  1  din qualifier.
REQ-008 SHALL have port din  input  WIDTH  rotated word from the upstream barrel shifter.
REQ-009 SHALL have port train  input  1  high marks din as a training word (SYNC_PAT rotated).
REQ-010 SHALL have port dout_valid  output  1  dout qualifier.
REQ-011 SHALL have port dout  output  WIDTH  din right-rotated by rot.
REQ-012 SHALL have port rot  output  log2(WIDTH)  current right-rotation amount.
REQ-013 SHALL have port locked  output  1  high in LOCKED state.

Function
REQ-014 SHALL implement FSM states SEARCH, CHECK, LOCKED; hit = (din right-rotated by rot == SYNC_PAT).
REQ-015 SEARCH, din_valid&train: hit -> CHECK with match count 1 (straight to LOCKED if LOCK_CNT==1); miss -> rot+1.
REQ-016 CHECK, din_valid&train: hit -> count+1, LOCKED when count reaches LOCK_CNT; miss -> SEARCH, rot+1, count cleared.
REQ-017 LOCKED, din_valid&train: miss -> miss count+1, at LOSS_CNT go to SEARCH with rot+1; hit clears miss count.
REQ-018 rot increment SHALL wrap WIDTH-1 -> 0 modulo WIDTH.
REQ-019 Words with train low SHALL not affect FSM, rot or counters in any state.
REQ-020 Cycles with din_valid low SHALL not change state, rot or counters.
REQ-021 dout/dout_valid SHALL be registered: dout_valid = din_valid delayed 1 cycle, in every state; dout uses rot in effect when din sampled.
REQ-022 rot and locked SHALL update on the same edge as the FSM transition causing them.

Reset
REQ-023 rst_n low SHALL asynchronously force SEARCH, rot=0, counters=0, locked=0, dout_valid=0, dout=0.
REQ-024 Reset mid-lock or mid-check SHALL discard all progress; search resumes from rot=0 after release.

Configuration
REQ-025 With ALIGN_STATS_EN defined SHALL add output relock_cnt 16 bits: +1 on each LOCKED->SEARCH transition, saturating at 16'hFFFF, reset 0.
REQ-026 Without ALIGN_STATS_EN SHALL have no relock_cnt port and no related logic.

Structure
REQ-027 Package barrel_align_pkg SHALL hold the FSM state typedef and default SYNC_PAT/LOCK_CNT/LOSS_CNT constants.
REQ-028 Rotation SHALL be one combinational sub-module barrel_rot (in, amt, right-rotate out), shared by hit compare and dout path.

Verification
REQ-029 Reset, then din=8'hE5 (0xBC rotated left 3), train=1, valid=1 for 6 words -> rot steps 0,1,2,3; locked=1 after 6th word, rot=3.
REQ-030 Locked at rot=3, data 8'h5A train=0 -> dout=8'h4B one cycle later; FSM unchanged.
REQ-031 Locked, two training words 8'h79 -> locked=0 after 2nd, rot=4; relock_cnt=1 when ALIGN_STATS_EN.
REQ-032 In CHECK at rot=3, one training word 8'h00 -> SEARCH, rot=4; valid=0 for 5 cycles -> no change.
REQ-033 Din 8'h79 training from rot=7 -> miss wraps rot to 0, then match at rot=1 after 2 words, CHECK entered.
REQ-034 rst_n asserted asynchronously mid-cycle while LOCKED -> outputs clear immediately, rot=0, locked=0.
